// File: rtl/lsu_pkg.sv
// Load/store unit shared types: access size codes, FSM states
// and the sub-word lane merge used by read-modify-write stores.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    MERGE
  } lsu_state_t;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [1:0]  off,
    input logic [1:0]  size
  );
    logic [31:0] w;
    w = old;
    unique case (1'b1)
      (size == SIZE_BYTE): w[{off, 3'b000} +: 8] = data[7:0];
      (size == SIZE_HALF): w[{off[1], 4'b0000} +: 16] = data[15:0];
      default:             w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Little-endian lane select for loads with sign or zero
// extension of byte and halfword results.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] load_data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        bs;
  logic        hs;

  assign b  = mem_rdata[{off, 3'b000} +: 8];
  assign h  = mem_rdata[{off[1], 4'b0000} +: 16];
  assign bs = b[7] & ~load_unsigned;
  assign hs = h[15] & ~load_unsigned;

  always_comb begin
    load_data = mem_rdata;
    unique case (1'b1)
      (size == SIZE_BYTE): load_data = {{24{bs}}, b};
      (size == SIZE_HALF): load_data = {{16{hs}}, h};
      default:             load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit32.sv
// Load/store unit in front of a word-only data RAM: sub-word
// loads, two-cycle read-modify-write sub-word stores, misalign trap.
module load_store_unit32
  import lsu_pkg::*;
#(
  parameter bit RMW_ENABLE = 1'b1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          store_data,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           size,
  input  logic                 load_unsigned,
  output logic [31:0]          load_data,
  output logic                 stall,
  output logic                 misaligned,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_write_data,
  output logic                 mem_wr,
  input  logic [31:0]          mem_rdata
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;

  lsu_state_t  state;
  lsu_state_t  state_nx;
  logic [31:0] old_word;
  logic [31:0] lat_data;
  logic [29:0] lat_waddr;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;

  logic        is_word;
  logic        is_half;
  logic        req;
  logic        bad_align;
  logic        mis;
  logic        idle;
  logic        sub_store;
  logic        word_store;
  logic        load_ok;
  logic [31:0] aligned;

  assign idle      = (state == IDLE);
  assign is_word   = size[1];
  assign is_half   = (size == SIZE_HALF);
  assign req       = mem_read | mem_write;
  assign bad_align = (is_word && alu_result[1:0] != 2'b00)
                   || (is_half && alu_result[0]);

  // Without RMW a sub-word store cannot be done safely, so trap it
  assign mis = idle && req
             && (bad_align || (mem_write && !is_word && !RMW_ENABLE));

  assign sub_store  = idle && mem_write && !is_word && !mis;
  assign word_store = idle && mem_write && is_word && !mis;
  assign load_ok    = idle && mem_read && !mem_write && !mis;
  assign misaligned = mis;

  lsu_load_align u_align (
    .mem_rdata     (mem_rdata),
    .off           (alu_result[1:0]),
    .size          (size),
    .load_unsigned (load_unsigned),
    .load_data     (aligned)
  );

  always_comb begin
    state_nx       = state;
    stall          = 1'b0;
    mem_wr         = 1'b0;
    mem_address    = {alu_result[31:2], 2'b00};
    mem_write_data = store_data;
    load_data      = '0;
    unique case (state)
      IDLE: begin
        mem_wr = word_store;
        if (load_ok) load_data = aligned;
        if (sub_store) begin
          stall    = 1'b1;
          state_nx = MERGE;
        end
      end
      MERGE: begin
        mem_address    = {lat_waddr, 2'b00};
        mem_write_data = lane_merge(old_word, lat_data,
                                    lat_off, lat_size);
        mem_wr         = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset aborts an in-flight merge write
    if (reset) begin
      mem_wr   = 1'b0;
      stall    = 1'b0;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      err_count <= '0;
    end else begin
      state <= state_nx;
      if (mis && err_count != '1) err_count <= err_count + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (sub_store) begin
      old_word  <= mem_rdata;
      lat_data  <= store_data;
      lat_waddr <= alu_result[31:2];
      lat_off   <= alu_result[1:0];
      lat_size  <= size;
    end
  end

endmodule

// File: tb/tb_load_store_unit32.sv
// Bench for load_store_unit32: directed table, RMW sequences and
// random traffic against a byte-array memory model.
module tb_load_store_unit32;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] load_data;
  logic        stall;
  logic        misaligned;
  logic [7:0]  err_count;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  load_store_unit32 dut (
    .clock          (clock),
    .reset          (reset),
    .alu_result     (alu_result),
    .store_data     (store_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .size           (size),
    .load_unsigned  (load_unsigned),
    .load_data      (load_data),
    .stall          (stall),
    .misaligned     (misaligned),
    .err_count      (err_count),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_wr         (mem_wr),
    .mem_rdata      (mem_rdata)
  );

  always #5 clock = ~clock;

  logic [31:0] ram [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;
  int          wr_count = 0;

  always @(posedge clock) begin
    if (pre_we) ram[pre_idx] <= pre_data;
    else if (mem_wr === 1'b1) begin
      ram[mem_address[7:2]] <= mem_write_data;
      wr_count++;
    end
  end

  assign mem_rdata = ram[mem_address[7:2]];

  logic [7:0] mb [0:255];
  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] exp_ld;
    logic        exp_mis;
  } vec_t;

  vec_t tv [0:10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [7:0] a);
    int b;
    b = {24'd0, a[7:2], 2'b00};
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  task automatic idle_in();
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_result    = '0;
    store_data    = '0;
    size          = 2'b10;
    load_unsigned = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    int b;
    @(negedge clock);
    idle_in();
    pre_we   = 1'b1;
    pre_idx  = a[7:2];
    pre_data = w;
    @(negedge clock);
    pre_we = 1'b0;
    b = {24'd0, a[7:2], 2'b00};
    for (int k = 0; k < 4; k++) mb[b+k] = w[8*k +: 8];
  endtask

  task automatic op(input logic [31:0] a, input logic [1:0] sz,
                    input logic rd, input logic wr, input logic uns,
                    input logic [31:0] d);
    logic        word;
    logic        mis;
    logic        req;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] exp_ld;
    int          b;
    @(negedge clock);
    alu_result    = a;
    size          = sz;
    mem_read      = rd;
    mem_write     = wr;
    load_unsigned = uns;
    store_data    = d;
    #2;
    word = sz[1];
    req  = rd | wr;
    mis  = req && ((word && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]));
    b    = {24'd0, a[7:2], 2'b00};
    w    = mword(a[7:0]);
    chk("err_count", {24'd0, err_count}, exp_err);
    chk("misaligned", {31'd0, misaligned}, {31'd0, mis});
    if (req) chk("mem_address", mem_address, {a[31:2], 2'b00});
    if (rd && !wr) begin
      if (mis) exp_ld = '0;
      else if (word) exp_ld = w;
      else if (sz == 2'b00) begin
        v = w >> (8 * a[1:0]);
        exp_ld = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      end else begin
        v = w >> (16 * a[1]);
        exp_ld = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      end
      chk("load_data", load_data, exp_ld);
    end else if (rd && wr) begin
      chk("load_data_both", load_data, 32'd0);
    end
    chk("stall", {31'd0, stall}, {31'd0, wr && !mis && !word});
    chk("mem_wr", {31'd0, mem_wr}, {31'd0, wr && !mis && word});
    if (wr && !mis && word) begin
      chk("wdata_word", mem_write_data, d);
      for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
    end
    if (mis && exp_err < 255) exp_err++;
    if (wr && !mis && !word) begin
      if (sz == 2'b00) mb[b + a[1:0]] = d[7:0];
      else begin
        mb[b + 2 * a[1]]     = d[7:0];
        mb[b + 2 * a[1] + 1] = d[15:8];
      end
      @(negedge clock);
      #2;
      chk("merge_wr", {31'd0, mem_wr}, 32'd1);
      chk("merge_stall", {31'd0, stall}, 32'd0);
      chk("merge_data", mem_write_data, mword(a[7:0]));
      chk("merge_addr", mem_address, {a[31:2], 2'b00});
    end
  endtask

  initial begin
    int wc0;
    logic [1:0] m;
    reset  = 1'b1;
    pre_we = 1'b0;
    pre_idx = '0;
    pre_data = '0;
    idle_in();
    @(negedge clock);
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    for (int i = 0; i < 64; i++) preload(8'(i * 4), 32'd0);

    tv[0]  = '{32'h11, 2'b00, 1'b0, 32'hFFFFFFAA, 1'b0};
    tv[1]  = '{32'h11, 2'b00, 1'b1, 32'h000000AA, 1'b0};
    tv[2]  = '{32'h12, 2'b01, 1'b0, 32'hFFFF8899, 1'b0};
    tv[3]  = '{32'h12, 2'b01, 1'b1, 32'h00008899, 1'b0};
    tv[4]  = '{32'h13, 2'b00, 1'b0, 32'hFFFFFF88, 1'b0};
    tv[5]  = '{32'h10, 2'b00, 1'b1, 32'h000000BB, 1'b0};
    tv[6]  = '{32'h10, 2'b10, 1'b0, 32'h8899AABB, 1'b0};
    tv[7]  = '{32'h13, 2'b10, 1'b0, 32'h00000000, 1'b1};
    tv[8]  = '{32'h11, 2'b01, 1'b0, 32'h00000000, 1'b1};
    tv[9]  = '{32'h10, 2'b01, 1'b0, 32'hFFFFAABB, 1'b0};
    tv[10] = '{32'h10, 2'b11, 1'b0, 32'h8899AABB, 1'b0};
    preload(8'h10, 32'h8899AABB);
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      alu_result    = tv[i].addr;
      size          = tv[i].sz;
      load_unsigned = tv[i].uns;
      mem_read      = 1'b1;
      mem_write     = 1'b0;
      #2;
      chk("tv_load", load_data, tv[i].exp_ld);
      chk("tv_mis", {31'd0, misaligned}, {31'd0, tv[i].exp_mis});
      if (tv[i].exp_mis) exp_err++;
    end

    preload(8'h20, 32'h11223344);
    wc0 = wr_count;
    op(32'h21, 2'b00, 1'b0, 1'b1, 1'b0, 32'h000000CC);
    @(negedge clock);
    idle_in();
    chk("sb_ram", ram[8], 32'h1122CC44);
    chk("sb_one_write", wr_count - wc0, 32'd1);
    op(32'h20, 2'b10, 1'b1, 1'b0, 1'b0, 32'd0);

    preload(8'h20, 32'h11223344);
    op(32'h22, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000BEEF);
    @(negedge clock);
    idle_in();
    chk("sh_ram", ram[8], 32'hBEEF3344);
    op(32'h24, 2'b10, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge clock);
    idle_in();
    chk("sw_ram", ram[9], 32'hDEADBEEF);

    wc0 = wr_count;
    op(32'h23, 2'b10, 1'b1, 1'b0, 1'b0, 32'd0);
    op(32'h25, 2'b01, 1'b0, 1'b1, 1'b0, 32'h1234);
    @(negedge clock);
    idle_in();
    #2;
    chk("mis_no_write", wr_count - wc0, 32'd0);
    chk("mis_count", {24'd0, err_count}, exp_err);

    preload(8'h40, 32'h11223344);
    wc0 = wr_count;
    @(negedge clock);
    alu_result = 32'h41;
    size       = 2'b00;
    mem_write  = 1'b1;
    store_data = 32'h55;
    #2;
    chk("rm_stall", {31'd0, stall}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk("rm_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rm_stall_rst", {31'd0, stall}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle_in();
    exp_err = 0;
    #2;
    chk("rm_err", {24'd0, err_count}, 32'd0);
    chk("rm_ram", ram[16], 32'h11223344);
    chk("rm_no_write", wr_count - wc0, 32'd0);
    op(32'h40, 2'b10, 1'b1, 1'b0, 1'b0, 32'd0);

    preload(8'h30, 32'd0);
    op(32'h30, 2'b00, 1'b0, 1'b1, 1'b0, 32'hAA);
    op(32'h31, 2'b00, 1'b0, 1'b1, 1'b0, 32'hBB);
    @(negedge clock);
    idle_in();
    chk("b2b_ram", ram[12], 32'h0000BBAA);

    for (int i = 0; i < 300; i++) begin
      m = 2'($urandom_range(0, 3));
      op({$urandom, 8'h00} | 32'($urandom_range(0, 255)),
         2'($urandom_range(0, 3)), m[0], m[1],
         1'($urandom_range(0, 1)), $urandom);
    end
    @(negedge clock);
    idle_in();
    for (int i = 0; i < 64; i++)
      chk("ram_final", ram[i], mword(8'(i * 4)));

    for (int i = 0; i < 260; i++)
      op(32'h23, 2'b10, 1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    idle_in();
    #2;
    chk("err_saturate", {24'd0, err_count}, 32'h000000FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
